// File: rtl/rx_pattern_checker.sv
// -----------------------------------------------------------------------------
// rx_pattern_checker
//
// Pulls 16-bit words from an RX FIFO (one read per cycle while data is
// available) and checks them against an incrementing byte-pair pattern:
// low byte = exp, high byte = exp + 1, exp advancing by 2 per word (mod 256).
// A SYNC state hunts for the first well-formed word; CHECK then tracks the
// sequence, resyncing on well-formed out-of-order words and dropping back to
// SYNC on malformed words.
//
// Ports
//   clk      in   single clock, all state on the rising edge
//   rst      in   asynchronous active-high reset
//   clr      in   synchronous clear of counters, flags and sync state
//   en       out  FIFO read enable (combinational: ~empty & ~rst & ~clr)
//   in       in   FIFO read data, valid the cycle after en
//   empty    in   FIFO empty flag
//   locked   out  high while in CHECK state (registered)
//   err      out  sticky error flag (registered)
//   word_cnt out  words consumed, wraps mod 2^CNT_WIDTH (registered)
//   err_cnt  out  errors detected, saturating (registered)
// -----------------------------------------------------------------------------
module rx_pattern_checker #(
  parameter int CNT_WIDTH = 24,
  parameter int ERR_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  output logic                 en,
  input  logic [15:0]          in,
  input  logic                 empty,
  output logic                 locked,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] word_cnt,
  output logic [ERR_WIDTH-1:0] err_cnt
);

  typedef enum logic [0:0] {
    ST_SYNC  = 1'b0,
    ST_CHECK = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ERR_WIDTH-1:0] ERR_ONE = {{(ERR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ERR_WIDTH-1:0] ERR_MAX = {ERR_WIDTH{1'b1}};

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_valid;
  logic [7:0]             r_exp;
  logic [7:0]             w_exp_nxt;
  logic                   w_err_evt;
  logic                   w_proc;
  logic                   w_wf;
  logic                   r_locked;
  logic                   r_err;
  logic [CNT_WIDTH-1:0]   r_word_cnt;
  logic [ERR_WIDTH-1:0]   r_err_cnt;

  // A word is well-formed when its high byte is its low byte plus one (mod 256).
  function automatic logic well_formed(input logic [15:0] word);
    logic [7:0] lo_plus_one;
    lo_plus_one = word[7:0] + 8'd1;
    return (word[15:8] == lo_plus_one);
  endfunction

  assign en     = ~empty & ~rst & ~clr;
  // clr wins over a word arriving in the same cycle: that word is dropped.
  assign w_proc = r_valid & ~clr;
  assign w_wf   = well_formed(in);

  // State register: SYNC after reset or clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_SYNC;
    end else if (clr) begin
      r_state <= ST_SYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: only a processed word can move the FSM.
  always_comb begin
    w_state_nxt = r_state;
    if (w_proc) begin
      case (r_state)
        ST_SYNC: begin
          if (w_wf) w_state_nxt = ST_CHECK;
          else      w_state_nxt = ST_SYNC;
        end
        ST_CHECK: begin
          if (w_wf) w_state_nxt = ST_CHECK;
          else      w_state_nxt = ST_SYNC;
        end
        default: w_state_nxt = ST_SYNC;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Output decode: next expected value and the per-word error event.
  always_comb begin
    w_exp_nxt = r_exp;
    w_err_evt = 1'b0;
    if (w_proc) begin
      case (r_state)
        ST_SYNC: begin
          if (w_wf) begin
            w_exp_nxt = in[7:0] + 8'd2;
          end else begin
            w_err_evt = 1'b1;
          end
        end
        ST_CHECK: begin
          if (!w_wf) begin
            w_err_evt = 1'b1;
          end else if (in[7:0] != r_exp) begin
            // Well-formed but out of sequence: count it and resync on it.
            w_err_evt = 1'b1;
            w_exp_nxt = in[7:0] + 8'd2;
          end else begin
            w_exp_nxt = r_exp + 8'd2;
          end
        end
        default: begin
          w_exp_nxt = 8'd0;
          w_err_evt = 1'b0;
        end
      endcase
    end else begin
      w_exp_nxt = r_exp;
      w_err_evt = 1'b0;
    end
  end

  // Datapath registers: read-latency flag, expected value, counters, flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_exp      <= 8'd0;
      r_word_cnt <= {CNT_WIDTH{1'b0}};
      r_err_cnt  <= {ERR_WIDTH{1'b0}};
      r_err      <= 1'b0;
      r_locked   <= 1'b0;
    end else if (clr) begin
      r_valid    <= 1'b0;
      r_exp      <= 8'd0;
      r_word_cnt <= {CNT_WIDTH{1'b0}};
      r_err_cnt  <= {ERR_WIDTH{1'b0}};
      r_err      <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_valid  <= en;
      r_exp    <= w_exp_nxt;
      r_locked <= (w_state_nxt == ST_CHECK);
      if (w_proc) begin
        r_word_cnt <= r_word_cnt + CNT_ONE;
      end else begin
        r_word_cnt <= r_word_cnt;
      end
      if (w_err_evt && (r_err_cnt != ERR_MAX)) begin
        r_err_cnt <= r_err_cnt + ERR_ONE;
      end else begin
        r_err_cnt <= r_err_cnt;
      end
      if (w_err_evt) begin
        r_err <= 1'b1;
      end else begin
        r_err <= r_err;
      end
    end
  end

  assign locked   = r_locked;
  assign err      = r_err;
  assign word_cnt = r_word_cnt;
  assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_rx_pattern_checker.sv
// -----------------------------------------------------------------------------
// tb_rx_pattern_checker
//
// Directed and randomized stimulus for rx_pattern_checker. A FIFO is modelled
// as a queue of words; a behavioural reference model applies the pattern
// rules to each word the DUT should consume. ERR_WIDTH is reduced to 4 so the
// saturation boundary is reachable with a handful of malformed words.
// -----------------------------------------------------------------------------
module tb_rx_pattern_checker;

  localparam int CW = 24;
  localparam int EW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          empty = 1'b1;
  logic [15:0]   din = 16'h0000;
  logic          en;
  logic          locked;
  logic          err;
  logic [CW-1:0] word_cnt;
  logic [EW-1:0] err_cnt;

  rx_pattern_checker #(.CNT_WIDTH(CW), .ERR_WIDTH(EW)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .en       (en),
    .in       (din),
    .empty    (empty),
    .locked   (locked),
    .err      (err),
    .word_cnt (word_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // FIFO contents and reference model state
  logic [15:0] fifo[$];
  bit          m_locked;
  bit          m_err;
  int          m_exp;
  longint      m_wc;
  int          m_ec;
  bit          m_valid;
  logic [15:0] m_word;
  int          n_fire;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_err    = 1'b0;
    m_exp    = 0;
    m_wc     = 0;
    m_ec     = 0;
    m_valid  = 1'b0;
  endtask

  task automatic model_error();
    m_err = 1'b1;
    if (m_ec < (1 << EW) - 1) m_ec++;
  endtask

  // Apply the pattern rules to one consumed word.
  task automatic model_word(input logic [15:0] w);
    int lo, hi;
    bit wf;
    lo = w[7:0];
    hi = w[15:8];
    wf = (hi == (lo + 1) % 256);
    m_wc = (m_wc + 1) % (64'd1 << CW);
    if (!m_locked) begin
      if (wf) begin
        m_exp    = (lo + 2) % 256;
        m_locked = 1'b1;
      end else begin
        model_error();
      end
    end else if (!wf) begin
      model_error();
      m_locked = 1'b0;
    end else if (lo != m_exp) begin
      model_error();
      m_exp = (lo + 2) % 256;
    end else begin
      m_exp = (m_exp + 2) % 256;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".locked"},   locked,   m_locked);
    check({tag, ".err"},      err,      m_err);
    check({tag, ".word_cnt"}, word_cnt, m_wc);
    check({tag, ".err_cnt"},  err_cnt,  m_ec);
  endtask

  // One clock cycle, entered and left at posedge+1.
  task automatic cycle(input bit want_empty, input bit c, input string tag);
    bit e, fire;
    e = want_empty || (fifo.size() == 0);
    empty = e;
    clr   = c;
    @(negedge clk);
    fire = !e && !c && !rst;
    check({tag, ".en"}, en, fire);
    @(posedge clk);
    if (c) model_reset();
    else if (m_valid) model_word(m_word);
    m_valid = fire;
    if (fire) n_fire++;
    #1;
    if (fire) begin
      m_word = fifo.pop_front();
      din    = m_word;
    end
    check_outputs(tag);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 2000 && (fifo.size() > 0 || m_valid); i++) cycle(1'b0, 1'b0, tag);
    check({tag, ".drained"}, fifo.size() + int'(m_valid), 0);
  endtask

  task automatic push_stream(input int start_lo, input int n);
    for (int i = 0; i < n; i++) begin
      int lo;
      lo = (start_lo + 2 * i) % 256;
      fifo.push_back({8'((lo + 1) % 256), 8'(lo)});
    end
  endtask

  initial begin
    model_reset();
    n_fire = 0;

    // Reset state: outputs zero, en masked even with data available.
    empty = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst.en", en, 1'b0);
    check_outputs("rst");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    empty = 1'b1;

    // 300-word clean stream, FIFO never empty.
    cycle(1'b1, 1'b1, "clr1");
    push_stream(0, 300);
    drain("s300");
    check("s300.word_cnt_300", word_cnt, 300);
    check("s300.err_cnt_0", err_cnt, 0);
    check("s300.err_0", err, 1'b0);
    check("s300.locked_1", locked, 1'b1);

    // Out-of-sequence well-formed word: single error, then resync.
    cycle(1'b1, 1'b1, "clr2");
    fifo = '{16'h0100, 16'h0302, 16'h0504, 16'h0A09, 16'h0C0B, 16'h0E0D};
    drain("resync");
    check("resync.err_cnt_1", err_cnt, 1);
    check("resync.err_1", err, 1'b1);
    check("resync.locked_1", locked, 1'b1);

    // Malformed word drops lock; next good word regains it.
    cycle(1'b1, 1'b1, "clr3");
    fifo = '{16'h0100, 16'h5555, 16'h0302};
    cycle(1'b0, 1'b0, "mf");
    cycle(1'b0, 1'b0, "mf");
    check("mf.locked_after_0100", locked, 1'b1);
    cycle(1'b0, 1'b0, "mf");
    check("mf.locked_after_5555", locked, 1'b0);
    cycle(1'b0, 1'b0, "mf");
    check("mf.locked_after_0302", locked, 1'b1);
    check("mf.err_cnt_1", err_cnt, 1);

    // empty toggling every cycle: word_cnt tracks cycles with en high.
    cycle(1'b1, 1'b1, "clr4");
    push_stream(8'h40, 40);
    n_fire = 0;
    for (int i = 0; i < 80; i++) cycle(i % 2 == 0, 1'b0, "tog");
    cycle(1'b1, 1'b0, "tog");
    check("tog.word_cnt_eq_en", word_cnt, n_fire);

    // Error counter saturation at all-ones.
    cycle(1'b1, 1'b1, "clr5");
    for (int i = 0; i < 14; i++) begin
      int lo;
      lo = $urandom_range(0, 255);
      fifo.push_back({8'((lo + 1 + $urandom_range(1, 254)) % 256), 8'(lo)});
    end
    drain("sat");
    check("sat.err_cnt_max_m1", err_cnt, 4'hE);
    fifo = '{16'h5555, 16'h0000, 16'hFFFF};
    drain("sat");
    check("sat.err_cnt_max", err_cnt, 4'hF);

    // Randomized mix of good, jumped and malformed words with random empty/clr.
    cycle(1'b1, 1'b1, "clr6");
    begin
      int lo;
      lo = $urandom_range(0, 127) * 2;
      for (int i = 0; i < 300; i++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 10) begin
          fifo.push_back(16'($urandom_range(0, 65535)));
        end else begin
          if (r < 15) lo = $urandom_range(0, 255);
          fifo.push_back({8'((lo + 1) % 256), 8'(lo)});
          lo = (lo + 2) % 256;
        end
      end
    end
    for (int i = 0; i < 2000 && (fifo.size() > 0 || m_valid); i++)
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0, "rnd");
    check("rnd.drained", fifo.size() + int'(m_valid), 0);

    // Mid-stream reset, then clr together with a valid word.
    cycle(1'b1, 1'b1, "clr7");
    push_stream(8'h10, 10);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, "mid");
    rst = 1'b1;
    #1;
    check("mid.rst_en", en, 1'b0);
    model_reset();
    check_outputs("mid.rst");
    @(posedge clk);
    #1 rst = 1'b0;
    check_outputs("mid.post_rst");
    cycle(1'b0, 1'b0, "mid.fetch");
    cycle(1'b0, 1'b1, "mid.clr");
    check("mid.word_cnt_0", word_cnt, 0);
    check("mid.locked_0", locked, 1'b0);
    check("mid.err_0", err, 1'b0);
    check("mid.err_cnt_0", err_cnt, 0);
    cycle(1'b0, 1'b0, "mid.resume");
    drain("mid.resume");
    check("mid.resume_locked", locked, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
